// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency memory among NUM_REQ
// requesters, with an owner lock for back-to-back bursts.
module mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req_read,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ-1:0]                   req_lock,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]                   req_grant,
  output logic [NUM_REQ-1:0]                   req_rvalid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic [DATA_WIDTH-1:0]                mem_writedata,
  input  logic [DATA_WIDTH-1:0]                mem_readdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant, lock_owner, lock_owner_nxt;
  logic [IW-1:0]   gidx, cand;
  logic            gvld, hold;
  logic            rvalid_q;
  logic [IW-1:0]   rvalid_owner;
  logic [NUM_REQ-1:0] requesting;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  assign requesting = req_read | req_write;
  // The lock only binds while its owner keeps req_lock high; a drop frees the port this cycle.
  assign hold = (state == LOCKED) && req_lock[lock_owner];

  always_comb begin
    gvld = 1'b0;
    gidx = '0;
    cand = '0;
    if (hold) begin
      gvld = requesting[lock_owner];
      gidx = lock_owner;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = rr_idx(last_grant, k);
        if (!gvld && requesting[cand]) begin
          gvld = 1'b1;
          gidx = cand;
        end
      end
    end
    if (!reset_n) gvld = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_grant[i]  = gvld && (gidx == IW'(i));
      req_rvalid[i] = rvalid_q && (rvalid_owner == IW'(i));
    end
  end

  // A read+write collision on one requester is issued as a read.
  assign mem_read      = gvld && req_read[gidx];
  assign mem_write     = gvld && req_write[gidx] && !req_read[gidx];
  assign mem_address   = gvld ? req_address[gidx] : '0;
  assign mem_writedata = gvld ? req_writedata[gidx] : '0;
  assign rd_data       = rvalid_q ? mem_readdata : '0;

  always_comb begin
    state_nxt      = IDLE;
    lock_owner_nxt = lock_owner;
    if (hold) begin
      state_nxt = LOCKED;
    end else if (gvld && req_lock[gidx]) begin
      state_nxt      = LOCKED;
      lock_owner_nxt = gidx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lock_owner   <= '0;
      last_grant   <= IW'(NUM_REQ - 1);
      rvalid_q     <= 1'b0;
      rvalid_owner <= '0;
    end else begin
      state        <= state_nxt;
      lock_owner   <= lock_owner_nxt;
      if (gvld) last_grant <= gidx;
      rvalid_q     <= mem_read;
      rvalid_owner <= gidx;
    end
  end
endmodule
